// File: rtl/phase_sequencer.sv
// Control stage for the phase-clocked gate adder: latches operands, sequences the
// t0 clear and ROUNDS t1/t2/t3 evaluation rounds, then captures the array result.
module phase_sequencer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned ROUNDS       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH:0]   sum_in,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             t0,
  output logic             t1,
  output logic             t2,
  output logic             t3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum_out
);

  localparam int unsigned PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [PW-1:0] PhaseLast = PW'(PHASE_CYCLES - 1);
  localparam logic [RW-1:0] RoundLast = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StCap
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [RW-1:0]    round_q, round_d;
  logic [WIDTH-1:0] a_d, b_d;
  logic [WIDTH:0]   sum_d;
  logic             done_d;
  logic             phase_last;

  assign phase_last = (phase_q == PhaseLast);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    round_d = round_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_out;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          phase_d = '0;
          state_d = StT0;
        end
      end
      StT0, StT1, StT2: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = (state_q == StT0) ? StT1 : (state_q == StT1) ? StT2 : StT3;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StT3: begin
        if (phase_last) begin
          phase_d = '0;
          if (round_q == RoundLast) begin
            round_d = '0;
            state_d = StCap;
          end else begin
            round_d = round_q + RW'(1);
            state_d = StT1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StCap: begin
        sum_d   = sum_in;
        done_d  = 1'b1;
        round_d = '0;
        phase_d = '0;
        state_d = StIdle;
      end
      default: begin
        phase_d = '0;
        round_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Strobes and busy are decoded from the next state so every output comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      round_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_out <= '0;
      done    <= 1'b0;
      t0      <= 1'b0;
      t1      <= 1'b0;
      t2      <= 1'b0;
      t3      <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      round_q <= round_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_out <= sum_d;
      done    <= done_d;
      t0      <= (state_d == StT0);
      t1      <= (state_d == StT1);
      t2      <= (state_d == StT2);
      t3      <= (state_d == StT3);
      busy    <= (state_d != StIdle);
    end
  end

endmodule
